spi_acl_master: RTL

//  Parametrised SPI mode-0 master for the ACL2 (ADXL362) accelerometer: issues register read,

---
 rtl/acl_spi_pkg.sv | 42 ++++
 rtl/spi_sclk_gen.sv | 40 ++++
 rtl/spi_acl_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/acl_spi_pkg.sv
// Shared types and constants for the ACL2 (ADXL362) SPI master: opcodes,
// instruction bytes, register map and FSM state encoding.
package acl_spi_pkg;

  typedef enum logic [1:0] {
    OP_REG_READ  = 2'b00,
    OP_FIFO_READ = 2'b01,
    OP_WRITE     = 2'b10,
    OP_RESERVED  = 2'b11
  } acl_op_t;

  localparam logic [7:0] INSTR_REG_READ  = 8'h0B;
  localparam logic [7:0] INSTR_FIFO_READ = 8'h0D;
  localparam logic [7:0] INSTR_WRITE     = 8'h0A;

  localparam logic [7:0] REG_XDATA        = 8'h08;
  localparam logic [7:0] REG_YDATA        = 8'h09;
  localparam logic [7:0] REG_ZDATA        = 8'h0A;
  localparam logic [7:0] REG_FIFO_CONTROL = 8'h28;
  localparam logic [7:0] REG_FIFO_SAMPLES = 8'h29;
  localparam logic [7:0] REG_POWER_CTL    = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_DATA,
    ST_CS_HOLD,
    ST_GAP,
    ST_ERR
  } state_t;

  function automatic logic [7:0] instr_byte(input acl_op_t op);
    case (op)
      OP_REG_READ:  return INSTR_REG_READ;
      OP_FIFO_READ: return INSTR_FIFO_READ;
      OP_WRITE:     return INSTR_WRITE;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts HALF_DIV cycles per half-period while enabled and
// flags the cycle on whose closing edge SCLK rises or falls.
module spi_sclk_gen #(
  parameter int HALF_DIV = 1221
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic tick
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] cnt;

  // With run low the divider still times half-periods but SCLK stays put.
  assign tick = en && (cnt == DIV_W'(HALF_DIV - 1));
  assign rise = tick && run && !sclk;
  assign fall = tick && run && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      if (run) sclk <= ~sclk;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_acl_master.sv
// SPI mode-0 master for the ACL2 accelerometer: register read, FIFO burst
// read and register write frames with a streaming byte interface.
module spi_acl_master
  import acl_spi_pkg::*;
#(
  parameter  int HALF_DIV  = 1221,
  parameter  int MAX_BYTES = 16,
  parameter  int CS_GAP    = 8,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       tx_data,
  output logic             tx_load,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             cmd_err,
  output logic             busy,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output state_t           dbg_state
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  // Command handshake: a command is taken on any cycle where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE once out of reset.

  state_t           state, state_nx;
  acl_op_t          op_q;
  logic [7:0]       addr_q;
  logic [LEN_W-1:0] len_q, len_eff, byte_cnt;
  logic [2:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       tx_sr;
  logic [6:0]       rx_sr;
  logic [7:0]       instr;
  logic             started;
  logic             sclk_en, sclk_run, rise, fall, tick;
  logic             accept, byte_done, last_byte, is_write;

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .en   (sclk_en),
    .run  (sclk_run),
    .sclk (sclk),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0)                        len_eff = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_BYTES))     len_eff = LEN_W'(MAX_BYTES);
  end

  assign instr     = instr_byte(acl_op_t'(cmd_op));
  assign cmd_ready = started && (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign byte_done = fall && (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == len_q - LEN_W'(1));
  assign is_write  = (op_q == OP_WRITE);
  assign mosi      = tx_sr[7];
  assign dbg_state = state;

  // The payload byte is popped on the same falling edge that shifts out its MSB.
  assign tx_load = byte_done && is_write &&
                   ((state == ST_ADDR) || ((state == ST_DATA) && !last_byte));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sclk_en  = 1'b0;
    sclk_run = 1'b0;
    busy     = 1'b0;
    cmd_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = (cmd_op == OP_RESERVED) ? ST_ERR : ST_INSTR;
      end
      ST_INSTR: begin
        sclk_en  = 1'b1;
        sclk_run = 1'b1;
        busy     = 1'b1;
        if (byte_done) state_nx = (op_q == OP_FIFO_READ) ? ST_DATA : ST_ADDR;
      end
      ST_ADDR: begin
        sclk_en  = 1'b1;
        sclk_run = 1'b1;
        busy     = 1'b1;
        if (byte_done) state_nx = ST_DATA;
      end
      ST_DATA: begin
        sclk_en  = 1'b1;
        sclk_run = 1'b1;
        busy     = 1'b1;
        if (byte_done && last_byte) state_nx = ST_CS_HOLD;
      end
      ST_CS_HOLD: begin
        sclk_en = 1'b1;
        busy    = 1'b1;
        if (tick) state_nx = ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nx = ST_IDLE;
      end
      ST_ERR: begin
        cmd_err  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      op_q     <= OP_REG_READ;
      addr_q   <= '0;
      len_q    <= LEN_W'(1);
      byte_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cs       <= 1'b1;
    end else begin
      started  <= 1'b1;
      rx_valid <= 1'b0;

      if (accept && (cmd_op != OP_RESERVED)) begin
        op_q     <= acl_op_t'(cmd_op);
        addr_q   <= cmd_addr;
        len_q    <= len_eff;
        tx_sr    <= instr;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        cs       <= 1'b0;
      end

      if (rise) begin
        rx_sr <= {rx_sr[5:0], miso};
        if ((state == ST_DATA) && (bit_cnt == 3'd7) && !is_write) begin
          rx_data  <= {rx_sr, miso};
          rx_valid <= 1'b1;
        end
      end

      if (fall) begin
        if (bit_cnt != 3'd7) begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b0};
        end else begin
          bit_cnt <= '0;
          case (state)
            ST_INSTR: tx_sr <= (op_q == OP_FIFO_READ) ? 8'h00 : addr_q;
            ST_ADDR:  tx_sr <= is_write ? tx_data : 8'h00;
            ST_DATA: begin
              byte_cnt <= byte_cnt + LEN_W'(1);
              tx_sr    <= (is_write && !last_byte) ? tx_data : 8'h00;
            end
            default: tx_sr <= 8'h00;
          endcase
        end
      end

      if ((state == ST_CS_HOLD) && tick) begin
        cs    <= 1'b1;
        tx_sr <= 8'h00;
      end

      if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                 gap_cnt <= '0;
    end
  end

endmodule
